// File: rtl/piezo_capture_pkg.sv
// rtl/piezo_capture_pkg.sv - shared widths and event record layout for piezo capture
package piezo_capture_pkg;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_TIME_W   = 32;

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Event record is {channel, time} with the channel in the MSBs.
    function automatic int evt_width(input int ch_w, input int time_w);
        return ch_w + time_w;
    endfunction

    localparam int DEF_CH_W = ch_width(DEF_CHANNELS);
    localparam int EVT_W    = evt_width(DEF_CH_W, DEF_TIME_W);

    typedef struct packed {
        logic [DEF_CH_W-1:0]   channel;
        logic [DEF_TIME_W-1:0] tstamp;
    } evt_t;

endpackage

// File: rtl/piezo_evt_fifo.sv
// rtl/piezo_evt_fifo.sv - synchronous show-ahead event FIFO with level output
module piezo_evt_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_ok     = pop && (level_q != '0);
        push_ready = (level_q != LW'(DEPTH)) || pop_ok;
    end

    always_comb begin
        push_ok  = push && push_ready;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_valid = (level_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;

endmodule

// File: rtl/piezo_event_capture.sv
// rtl/piezo_event_capture.sv - multi-channel piezo edge timestamping front end
module piezo_event_capture
    import piezo_capture_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int TIME_W       = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int FILTER_LEN   = 4,
    parameter int BLANK_CYCLES = 64,
    localparam int CH_W        = ch_width(CHANNELS),
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                iCLK,
    input  logic                iRESET,
    input  logic [CHANNELS-1:0] iPIEZO_IN,
    input  logic [CHANNELS-1:0] iCH_ENABLE,
    input  logic [TIME_W-1:0]   iTIME,
    input  logic                iTX_ACTIVE,
    output logic                oEVT_VALID,
    input  logic                iEVT_READY,
    output logic [CH_W-1:0]     oEVT_CHANNEL,
    output logic [TIME_W-1:0]   oEVT_TIME,
    output logic [LVL_W-1:0]    oFIFO_LEVEL,
    output logic [15:0]         oOVERFLOW_CNT,
    input  logic                iOVF_CLEAR,
    output logic                oBLANKING
);

    localparam int EVT_WIDTH = evt_width(CH_W, TIME_W);
    localparam int CNT_W     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int BLK_W     = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    logic                 tx_q, tx_d;
    logic [BLK_W-1:0]     blank_cnt_q, blank_cnt_d, blank_eff;
    logic                 blanking;
    logic [CHANNELS-1:0]  pending, drop, take, grant_oh;
    logic [TIME_W-1:0]    ptime [CHANNELS];
    logic [CH_W-1:0]      grant_idx;
    logic [TIME_W-1:0]    grant_time;
    logic                 push_req, push_ready;
    logic [15:0]          ovf_q, ovf_d;
    logic [4:0]           drop_cnt;
    logic [16:0]          ovf_sum;
    logic [EVT_WIDTH-1:0] head_data;
    logic                 head_valid;

    // The guard counter is seen as already loaded in the cycle the fall is detected,
    // so there is no unblanked hole between TX dropping and the guard starting.
    always_comb begin
        tx_d        = iTX_ACTIVE;
        blank_eff   = (tx_q && !iTX_ACTIVE) ? BLK_W'(BLANK_CYCLES) : blank_cnt_q;
        blanking    = iTX_ACTIVE || (blank_eff != '0);
        blank_cnt_d = (iTX_ACTIVE || (blank_eff == '0)) ? '0 : blank_eff - 1'b1;
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic              sync1_q, sync1_d, sync2_q, sync2_d;
        logic              filt_q, filt_d, pend_q, pend_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [TIME_W-1:0] t0_q, t0_d, ptime_q, ptime_d, run_t0;
        logic              qualify, evt;

        // run_t0 covers FILTER_LEN=1, where the run starts and qualifies in one cycle.
        always_comb begin
            sync1_d = iPIEZO_IN[ch];
            sync2_d = sync1_q;
            cnt_d   = '0;
            t0_d    = t0_q;
            filt_d  = filt_q;
            qualify = 1'b0;
            run_t0  = (cnt_q == '0) ? iTIME : t0_q;
            if (sync2_q != filt_q) begin
                t0_d = run_t0;
                if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                    filt_d  = sync2_q;
                    qualify = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        assign evt = qualify && sync2_q && iCH_ENABLE[ch] && !blanking;

        always_comb begin
            pend_d  = pend_q;
            ptime_d = ptime_q;
            if (evt && !pend_q) begin
                pend_d  = 1'b1;
                ptime_d = run_t0;
            end else if (take[ch]) begin
                pend_d = 1'b0;
            end
        end

        always_ff @(posedge iCLK) begin
            if (iRESET) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                filt_q  <= 1'b0;
                cnt_q   <= '0;
                t0_q    <= '0;
                pend_q  <= 1'b0;
                ptime_q <= '0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                filt_q  <= filt_d;
                cnt_q   <= cnt_d;
                t0_q    <= t0_d;
                pend_q  <= pend_d;
                ptime_q <= ptime_d;
            end
        end

        assign pending[ch] = pend_q;
        assign drop[ch]    = evt && pend_q;
        assign ptime[ch]   = ptime_q;
    end

    always_comb begin
        push_req   = 1'b0;
        grant_idx  = '0;
        grant_time = '0;
        grant_oh   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pending[i] && !push_req) begin
                push_req     = 1'b1;
                grant_idx    = CH_W'(i);
                grant_time   = ptime[i];
                grant_oh[i]  = 1'b1;
            end
        end
    end

    assign take = grant_oh & {CHANNELS{push_ready}};

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            drop_cnt = drop_cnt + 5'(drop[i]);
        end
        ovf_sum = {1'b0, ovf_q} + 17'(drop_cnt);
        if (iOVF_CLEAR) begin
            ovf_d = '0;
        end else if (ovf_sum[16]) begin
            ovf_d = 16'hFFFF;
        end else begin
            ovf_d = ovf_sum[15:0];
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            tx_q        <= 1'b0;
            blank_cnt_q <= '0;
            ovf_q       <= '0;
        end else begin
            tx_q        <= tx_d;
            blank_cnt_q <= blank_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    piezo_evt_fifo #(
        .WIDTH (EVT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (iCLK),
        .reset      (iRESET),
        .push       (push_req),
        .push_data  ({grant_idx, grant_time}),
        .push_ready (push_ready),
        .pop        (iEVT_READY),
        .head_valid (head_valid),
        .head_data  (head_data),
        .level      (oFIFO_LEVEL)
    );

    assign oEVT_VALID    = head_valid;
    assign oEVT_CHANNEL  = head_data[EVT_WIDTH-1 -: CH_W];
    assign oEVT_TIME     = head_data[TIME_W-1:0];
    assign oOVERFLOW_CNT = ovf_q;
    assign oBLANKING     = blanking;

endmodule

// File: tb/tb_piezo_event_capture.sv
// tb/tb_piezo_event_capture.sv - self-checking bench for piezo_event_capture
module tb_piezo_event_capture;

    localparam int CH    = 4;
    localparam int TW    = 32;
    localparam int DEPTH = 16;
    localparam int FL    = 4;
    localparam int BLANK = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, tx, ready, ovf_clr;
    logic [CH-1:0] piezo, en;
    logic [TW-1:0] tim;
    logic          evt_valid, blanking_o;
    logic [1:0]    evt_ch;
    logic [TW-1:0] evt_time;
    logic [4:0]    level;
    logic [15:0]   ovf_cnt;

    piezo_event_capture #(
        .CHANNELS(CH), .TIME_W(TW), .FIFO_DEPTH(DEPTH),
        .FILTER_LEN(FL), .BLANK_CYCLES(BLANK)
    ) dut (
        .iCLK          (clk),
        .iRESET        (rst),
        .iPIEZO_IN     (piezo),
        .iCH_ENABLE    (en),
        .iTIME         (tim),
        .iTX_ACTIVE    (tx),
        .oEVT_VALID    (evt_valid),
        .iEVT_READY    (ready),
        .oEVT_CHANNEL  (evt_ch),
        .oEVT_TIME     (evt_time),
        .oFIFO_LEVEL   (level),
        .oOVERFLOW_CNT (ovf_cnt),
        .iOVF_CLEAR    (ovf_clr),
        .oBLANKING     (blanking_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: synced level = raw input two cycles back; an edge is accepted once
    // the synced level has held a new value for FL samples; its time is when that run began.
    typedef struct packed {
        logic [1:0]    ch;
        logic [TW-1:0] t;
    } mevt_t;

    mevt_t         mq[$];
    logic [CH-1:0] rawq[$];
    bit            m_f[CH], m_prev_s[CH], m_pend[CH];
    int            m_run_len[CH];
    logic [TW-1:0] m_run_t[CH], m_ptime[CH];
    int            m_ovf, m_fall_cyc, cyc, tinc;
    bit            m_prev_tx, m_fall_valid, chk_en;

    task automatic m_reset();
        mq.delete();
        rawq.delete();
        rawq.push_back('0);
        rawq.push_back('0);
        for (int c = 0; c < CH; c++) begin
            m_f[c] = 0; m_prev_s[c] = 0; m_pend[c] = 0;
            m_run_len[c] = 0; m_run_t[c] = '0; m_ptime[c] = '0;
        end
        m_ovf = 0;
        m_prev_tx = 0;
        m_fall_valid = 0;
        m_fall_cyc = 0;
    endtask

    task automatic step();
        bit    fall_now, fv, m_blank, pop, acc, s;
        int    fc, gi, drops;
        mevt_t e;
        bit    pend_old[CH];
        #1;
        fall_now = m_prev_tx && !tx;
        fc       = fall_now ? cyc : m_fall_cyc;
        fv       = fall_now || m_fall_valid;
        m_blank  = tx || (fv && (cyc - fc) < BLANK);
        if (chk_en) begin
            check_eq("valid", 64'(evt_valid), 64'(mq.size() > 0));
            check_eq("level", 64'(level), 64'(mq.size()));
            check_eq("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
            check_eq("blanking", 64'(blanking_o), 64'(m_blank));
            if (mq.size() > 0) begin
                check_eq("head_ch", 64'(evt_ch), 64'(mq[0].ch));
                check_eq("head_time", 64'(evt_time), 64'(mq[0].t));
            end
        end
        if (rst) begin
            m_reset();
        end else begin
            m_fall_cyc   = fc;
            m_fall_valid = fv;
            m_prev_tx    = tx;
            pop = (mq.size() > 0) && ready;
            gi  = -1;
            for (int c = 0; c < CH; c++) if (m_pend[c] && gi < 0) gi = c;
            acc = (gi >= 0) && ((mq.size() < DEPTH) || pop);
            pend_old = m_pend;
            drops = 0;
            for (int c = 0; c < CH; c++) begin
                s = rawq[0][c];
                if (s != m_prev_s[c]) begin
                    m_run_len[c] = 1;
                    m_run_t[c]   = tim;
                end else begin
                    m_run_len[c]++;
                end
                m_prev_s[c] = s;
                if (s != m_f[c] && m_run_len[c] >= FL) begin
                    m_f[c] = s;
                    if (s && en[c] && !m_blank) begin
                        if (pend_old[c]) drops++;
                        else begin
                            m_pend[c]  = 1;
                            m_ptime[c] = m_run_t[c];
                        end
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (acc) begin
                e.ch = 2'(gi);
                e.t  = m_ptime[gi];
                mq.push_back(e);
                m_pend[gi] = 0;
            end
            if (ovf_clr) m_ovf = 0;
            else m_ovf = (m_ovf + drops > 65535) ? 65535 : m_ovf + drops;
            rawq.push_back(piezo);
            void'(rawq.pop_front());
        end
        cyc++;
        @(negedge clk);
        tim = tim + TW'(tinc);
    endtask

    task automatic rand_inputs(input bit allow_tx);
        for (int c = 0; c < CH; c++) if ($urandom_range(4) == 0) piezo[c] = ~piezo[c];
        if ($urandom_range(199) == 0) en = CH'($urandom);
        if (allow_tx) begin
            if (tx) tx = ($urandom_range(9) != 0);
            else    tx = ($urandom_range(149) == 0);
        end
        tinc = $urandom_range(1, 3);
    endtask

    initial begin
        cyc = 0; tinc = 1; chk_en = 0;
        rst = 1; tx = 0; ready = 0; ovf_clr = 0; piezo = '0; en = '1; tim = 0;
        m_reset();
        repeat (3) step();
        rst = 0;
        chk_en = 1;
        #1;
        check_eq("rst_valid", 64'(evt_valid), 64'd0);
        check_eq("rst_level", 64'(level), 64'd0);
        check_eq("rst_ovf", 64'(ovf_cnt), 64'd0);
        repeat (5) step();

        // single rising edge on ch2 starting at time 1000
        tim = 1000;
        piezo[2] = 1'b1;
        repeat (12) step();
        #1;
        check_eq("ch2_valid", 64'(evt_valid), 64'd1);
        check_eq("ch2_chan", 64'(evt_ch), 64'd2);
        check_eq("ch2_time", 64'(evt_time), 64'd1002);
        ready = 1;
        piezo[2] = 1'b0;
        repeat (10) step();

        // short glitch is rejected, long pulse is accepted
        piezo[1] = 1'b1;
        repeat (3) step();
        piezo[1] = 1'b0;
        repeat (10) step();
        #1;
        check_eq("glitch_level", 64'(level), 64'd0);
        piezo[1] = 1'b1;
        repeat (10) step();
        piezo[1] = 1'b0;
        repeat (10) step();

        // TX blanking and guard window
        tx = 1;
        repeat (20) step();
        tx = 0;
        repeat (25) step();
        piezo[0] = 1'b1;
        repeat (5) step();
        #1;
        check_eq("guard_blank", 64'(blanking_o), 64'd1);
        repeat (10) step();
        piezo[0] = 1'b0;
        repeat (25) step();
        piezo[0] = 1'b1;
        repeat (5) step();
        #1;
        check_eq("guard_over", 64'(blanking_o), 64'd0);
        repeat (10) step();
        piezo[0] = 1'b0;
        repeat (10) step();

        // simultaneous ch0/ch3 edges
        ready = 0;
        piezo = 4'b1001;
        repeat (10) step();
        #1;
        check_eq("same_first", 64'(evt_ch), 64'd0);
        ready = 1;
        step();
        #1;
        check_eq("same_second", 64'(evt_ch), 64'd3);
        piezo = '0;
        repeat (15) step();

        // fill FIFO, pending 17th, overflow, pop refills
        ready = 0;
        for (int i = 0; i < 17; i++) begin
            piezo = CH'(1 << (i % CH));
            repeat (6) step();
        end
        piezo = '0;
        repeat (12) step();
        #1;
        check_eq("full_level", 64'(level), 64'd16);
        piezo[0] = 1'b1;
        repeat (8) step();
        piezo[0] = 1'b0;
        repeat (8) step();
        #1;
        check_eq("ovf_one", 64'(ovf_cnt), 64'd1);
        ready = 1;
        step();
        ready = 0;
        repeat (3) step();
        #1;
        check_eq("refill_level", 64'(level), 64'd16);
        ovf_clr = 1;
        step();
        ovf_clr = 0;
        #1;
        check_eq("ovf_clear", 64'(ovf_cnt), 64'd0);

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            rand_inputs(1'b1);
            ready   = ($urandom_range(2) != 0);
            ovf_clr = ($urandom_range(59) == 0);
            step();
        end
        ovf_clr = 0;
        tx = 0;
        repeat (70) step();

        // reset with content in the FIFO
        ready = 0;
        en = '1;
        for (int n = 0; n < 400 && mq.size() < 5; n++) begin
            rand_inputs(1'b0);
            step();
        end
        check_eq("fill_to_5", 64'(level >= 5), 64'd1);
        rst = 1;
        step();
        rst = 0;
        #1;
        check_eq("mid_rst_valid", 64'(evt_valid), 64'd0);
        check_eq("mid_rst_level", 64'(level), 64'd0);
        check_eq("mid_rst_ovf", 64'(ovf_cnt), 64'd0);
        piezo = '0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
